// File: rtl/rv_decode_stage_if.sv
// Fetch/decode/EX handshake and ID/EX control word of the RV32 decode stage.
// The master drives the instruction and EX resolution, the slave is the decode stage.
interface rv_decode_stage_if #(
    parameter int unsigned NUM_GPIO = 4
);
    logic                instr_valid;
    logic [31:0]         instr;
    logic                ex_resolve;
    logic                ctl_valid;
    logic                alusrc;
    logic                regwrite;
    logic [1:0]          regsel;
    logic [3:0]          op;
    logic [2:0]          branch;
    logic                x_ex;
    logic [1:0]          pcsrc;
    logic [NUM_GPIO-1:0] gpio_we;
    logic                illegal;
    logic                stall_fetch;

    modport master (
        output instr_valid, instr, ex_resolve,
        input  ctl_valid, alusrc, regwrite, regsel, op, branch, x_ex, pcsrc,
               gpio_we, illegal, stall_fetch
    );

    modport slave (
        input  instr_valid, instr, ex_resolve,
        output ctl_valid, alusrc, regwrite, regsel, op, branch, x_ex, pcsrc,
               gpio_we, illegal, stall_fetch
    );
endinterface

// File: rtl/rv_decode_stage.sv
// Registered RV32 decode stage: combinational decoder, ID/EX control register,
// control-hazard / multiply-stall FSM and GPIO write-enable decode for csrrw.
module rv_decode_stage #(
    parameter int unsigned NUM_GPIO  = 4,
    parameter logic [11:0] GPIO_BASE = 12'h002,
    parameter int unsigned MUL_LAT   = 3
) (
    input logic              clk,
    input logic              rst_n,
    rv_decode_stage_if.slave bus
);
    localparam int unsigned          CNT_W      = $clog2(MUL_LAT) + 1;
    localparam logic [CNT_W-1:0]     CNT_LOAD   = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
    localparam bit                   MUL_STALLS = (MUL_LAT > 1);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000, ALU_OR   = 4'b0001, ALU_XOR  = 4'b0010,
        ALU_ADD   = 4'b0011, ALU_SUB  = 4'b0100, ALU_MUL  = 4'b0101,
        ALU_MULH  = 4'b0110, ALU_MULHU = 4'b0111, ALU_SLL = 4'b1000,
        ALU_SRL   = 4'b1001, ALU_SRA  = 4'b1011, ALU_SLT  = 4'b1100,
        ALU_SLTU  = 4'b1101
    } alu_op_t;

    typedef enum logic [1:0] {S_RUN, S_CWAIT, S_MBUSY} state_t;

    typedef struct packed {
        logic       ctl_valid;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] regsel;
        alu_op_t    op;
        logic [2:0] branch;
        logic       x_ex;
        logic [1:0] pcsrc;
        logic       illegal;
    } ctl_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm12;
    logic        unused_fields;

    assign opcode        = bus.instr[6:0];
    assign funct3        = bus.instr[14:12];
    assign funct7        = bus.instr[31:25];
    assign imm12         = bus.instr[31:20];
    assign unused_fields = ^{bus.instr[19:15], bus.instr[11:7]};

    ctl_t                dec;
    logic [NUM_GPIO-1:0] dec_gpio;
    logic                dec_ctrl;
    logic                dec_mul;
    logic                legal;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        dec      = '0;
        dec_gpio = '0;
        dec_ctrl = 1'b0;
        dec_mul  = 1'b0;
        legal    = 1'b1;
        unique case (opcode)
            OPC_OP: begin
                dec.regwrite = 1'b1;
                dec.regsel   = 2'b10;
                case ({funct7, funct3})
                    10'b0000000_000: dec.op = ALU_ADD;
                    10'b0100000_000: dec.op = ALU_SUB;
                    10'b0000000_111: dec.op = ALU_AND;
                    10'b0000000_110: dec.op = ALU_OR;
                    10'b0000000_100: dec.op = ALU_XOR;
                    10'b0000000_001: dec.op = ALU_SLL;
                    10'b0000000_101: dec.op = ALU_SRL;
                    10'b0100000_101: dec.op = ALU_SRA;
                    10'b0000000_010: dec.op = ALU_SLT;
                    10'b0000000_011: dec.op = ALU_SLTU;
                    10'b0000001_000: begin dec.op = ALU_MUL;   dec_mul = 1'b1; end
                    10'b0000001_001: begin dec.op = ALU_MULH;  dec_mul = 1'b1; end
                    10'b0000001_011: begin dec.op = ALU_MULHU; dec_mul = 1'b1; end
                    default:         legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec.regsel   = 2'b10;
                case (funct3)
                    3'b000: dec.op = ALU_ADD;
                    3'b111: dec.op = ALU_AND;
                    3'b110: dec.op = ALU_OR;
                    3'b100: dec.op = ALU_XOR;
                    3'b001: if (funct7 == 7'b0000000) dec.op = ALU_SLL; else legal = 1'b0;
                    3'b101: begin
                        if (funct7 == 7'b0000000)      dec.op = ALU_SRL;
                        else if (funct7 == 7'b0100000) dec.op = ALU_SRA;
                        else                           legal  = 1'b0;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                dec.regwrite = 1'b1;
                dec.regsel   = 2'b01;
            end
            OPC_BRANCH: begin
                // x_ex = 1: taken on a zero ALU result (equal, or "not less than").
                dec.pcsrc = 2'b01;
                dec_ctrl  = 1'b1;
                case (funct3)
                    3'b000:  begin dec.op = ALU_SUB;  dec.branch = 3'b000; dec.x_ex = 1'b1; end
                    3'b101:  begin dec.op = ALU_SLT;  dec.branch = 3'b001; dec.x_ex = 1'b1; end
                    3'b111:  begin dec.op = ALU_SLTU; dec.branch = 3'b010; dec.x_ex = 1'b1; end
                    3'b100:  begin dec.op = ALU_SLT;  dec.branch = 3'b011; end
                    3'b110:  begin dec.op = ALU_SLTU; dec.branch = 3'b100; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_JAL: begin
                dec.op       = ALU_ADD;
                dec.pcsrc    = 2'b10;
                dec.regsel   = 2'b11;
                dec.regwrite = 1'b1;
                dec_ctrl     = 1'b1;
            end
            OPC_JALR: begin
                dec.op       = ALU_ADD;
                dec.alusrc   = 1'b1;
                dec.pcsrc    = 2'b11;
                dec.regsel   = 2'b11;
                dec.regwrite = 1'b1;
                dec_ctrl     = 1'b1;
                if (funct3 != 3'b000) legal = 1'b0;
            end
            OPC_SYSTEM: begin
                if (funct3 != 3'b001) begin
                    legal = 1'b0;
                end else if (imm12 == 12'h000) begin
                    dec.regwrite = 1'b1;
                    dec.regsel   = 2'b00;
                end else begin
                    for (int i = 0; i < int'(NUM_GPIO); i++) begin
                        if (imm12 == GPIO_BASE + 12'(i)) dec_gpio[i] = 1'b1;
                    end
                    if (dec_gpio == '0) legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase

        // An undecodable word collapses to a bubble flagged illegal, with no side effects.
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
            dec_gpio    = '0;
            dec_ctrl    = 1'b0;
            dec_mul     = 1'b0;
        end else begin
            dec.ctl_valid = 1'b1;
        end
    end

    state_t           state, state_n;
    logic [CNT_W-1:0] busy_cnt, busy_cnt_n;
    logic             accept;
    logic             stall;

    always_comb begin
        state_n    = state;
        busy_cnt_n = busy_cnt;
        accept     = 1'b0;
        stall      = 1'b0;
        unique case (state)
            S_RUN: begin
                accept = bus.instr_valid;
                if (bus.instr_valid && dec_ctrl) begin
                    stall   = 1'b1;
                    state_n = S_CWAIT;
                end else if (bus.instr_valid && dec_mul && MUL_STALLS) begin
                    stall      = 1'b1;
                    state_n    = S_MBUSY;
                    busy_cnt_n = CNT_LOAD;
                end
            end
            S_CWAIT: begin
                stall = 1'b1;
                if (bus.ex_resolve) state_n = S_RUN;
            end
            S_MBUSY: begin
                stall      = 1'b1;
                busy_cnt_n = busy_cnt - CNT_ONE;
                if (busy_cnt <= CNT_ONE) state_n = S_RUN;
            end
            default: state_n = S_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RUN;
            busy_cnt <= '0;
        end else begin
            state    <= state_n;
            busy_cnt <= busy_cnt_n;
        end
    end

    ctl_t                ctl_q;
    logic [NUM_GPIO-1:0] gpio_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q  <= '0;
            gpio_q <= '0;
        end else if (accept) begin
            ctl_q  <= dec;
            gpio_q <= dec_gpio;
        end else begin
            ctl_q  <= '0;
            gpio_q <= '0;
        end
    end

    assign bus.ctl_valid   = ctl_q.ctl_valid;
    assign bus.alusrc      = ctl_q.alusrc;
    assign bus.regwrite    = ctl_q.regwrite;
    assign bus.regsel      = ctl_q.regsel;
    assign bus.op          = ctl_q.op;
    assign bus.branch      = ctl_q.branch;
    assign bus.x_ex        = ctl_q.x_ex;
    assign bus.pcsrc       = ctl_q.pcsrc;
    assign bus.gpio_we     = gpio_q;
    assign bus.illegal     = ctl_q.illegal;
    assign bus.stall_fetch = stall;
endmodule

// File: doc/rv_decode_stage.md
# rv_decode_stage

Registered decode stage for the RV32 core: turns a fetched instruction into the ID/EX control word one cycle later. It generalises the combinational control decoder into a stage with its own control-hazard FSM, a multi-cycle multiply stall counter, and a parametrised bank of GPIO output channels. It sits between the fetch register and the EX stage. It drives `stall_fetch` back to fetch and receives branch/jump resolution from EX.

## Interface
- `NUM_GPIO`, 4: number of GPIO output channels written by `csrrw`; range 1..8.
- `GPIO_BASE`, 12'h002: CSR address of channel 0; channel i is at `GPIO_BASE+i`.
- `MUL_LAT`, 3: EX cycles taken by `mul`/`mulh`/`mulhu`; range 1..8.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: `instr` holds a fetched instruction this cycle.
- `instr` in 32: instruction word.
- `ex_resolve` in 1: EX has resolved the outstanding branch or jump; one-cycle pulse.
- `ctl_valid` out 1: the ID/EX control word is a real instruction, not a bubble.
- `alusrc` out 1: 1 selects the immediate as ALU operand B.
- `regwrite` out 1: register file write enable.
- `regsel` out 2: writeback source. 00 = io input, 01 = lui immediate, 10 = ALU, 11 = PC+4.
- `op` out 4: ALU op. and 0000, or 0001, xor 0010, add 0011, sub 0100, mul 0101, mulh 0110, mulhu 0111, sll 1000, srl 1001, sra 1011, slt 1100, sltu 1101.
- `branch` out 3: branch type. beq 000, bge 001, bgeu 010, blt 011, bltu 100.
- `x_ex` out 1: 1 means the branch is taken when the ALU result is zero (beq/bge/bgeu); 0 means taken when non-zero (blt/bltu).
- `pcsrc` out 2: 00 = PC+4, 01 = branch, 10 = jal, 11 = jalr.
- `gpio_we` out NUM_GPIO: one-hot write enable for the GPIO channels.
- `illegal` out 1: the accepted instruction was not decodable.
- `stall_fetch` out 1: fetch holds its PC and instruction this cycle. Combinational.

## Operation
- Supported instructions:
  - R-type: add, sub, and, or, xor, sll, srl, sra, slt, sltu, mul, mulh, mulhu.
  - I-type: addi, andi, ori, xori, slli, srli, srai. The shift instructions require `imm12[11:5]` = 0000000, or 0100000 for srai.
  - lui.
  - Branches: beq, bge, bgeu, blt, bltu.
  - Jumps: jal, and jalr with funct3 = 000.
  - csrrw (opcode 1110011, funct3 001):
    - `imm12` = 0: io read. `regsel` = 00, `regwrite` = 1.
    - `imm12` = `GPIO_BASE+i` with i < NUM_GPIO: `gpio_we[i]` = 1, `regwrite` = 0.
- Any other encoding is illegal. It registers a bubble: `ctl_valid` = 0, `illegal` = 1, and every write enable is 0.
- An instruction is accepted when `instr_valid` = 1 and the FSM is in RUN. Its decoded word is registered at the next rising edge.
- If no instruction is accepted in a cycle, the next ID/EX word is a bubble: all outputs 0, including `illegal`.
- Branches force `alusrc` = 0 and `regwrite` = 0.
- jal and jalr force `regsel` = 11 and `regwrite` = 1.
- FSM states:
  - RUN:
    - Accepting a branch, jal or jalr moves to CWAIT.
    - Accepting a mul-class instruction with MUL_LAT > 1 loads `busy_cnt` = MUL_LAT-1 and moves to MBUSY.
    - Otherwise stays in RUN.
  - CWAIT:
    - `ex_resolve` = 1 moves to RUN. The instruction presented in that cycle is not accepted.
    - Otherwise stays in CWAIT.
  - MBUSY: `busy_cnt` decrements each cycle. The FSM moves to RUN on the cycle `busy_cnt` = 1.
- `stall_fetch` = 1 when either:
  - the FSM is not in RUN; or
  - the FSM is in RUN, `instr_valid` = 1, and `instr` is a branch, jump, or mul-class instruction with MUL_LAT > 1.
- `ex_resolve` is ignored in RUN and MBUSY.
- The ALU op field width is fixed at 4 bits. `gpio_we` is exactly NUM_GPIO bits wide.
- The `busy_cnt` width is $clog2(MUL_LAT)+1.

## Timing
- Decode latency: 1 cycle from acceptance to the ID/EX outputs.
- Reset (`rst_n` low, asynchronous):
  - Every output is cleared to 0 immediately.
  - The FSM goes to RUN and `busy_cnt` goes to 0.
  - `stall_fetch` then follows its combinational rule, so it goes to 0 unless a branch, jump or multi-cycle mul is being presented.
- Reset asserted in CWAIT or MBUSY abandons the pending wait with no residual stall.
- A branch accepted in cycle t:
  - Its control word is valid in t+1.
  - `stall_fetch` is 1 from t until the cycle `ex_resolve` is seen, inclusive.
  - Acceptance resumes in the cycle after that.
- With MUL_LAT = N > 1, a mul accepted in cycle t gives:
  - `ctl_valid` = 1 in t+1.
  - Bubbles in t+2 through t+N.
  - The next instruction is accepted at t+N and appears at t+N+1.
- With MUL_LAT = 1, a mul behaves like any ALU instruction: no stall.
- Back-to-back ALU instructions give one control word per cycle with no bubbles.

## Test plan
- Reset then `add` x3,x1,x2 (32'h002081B3) → the next cycle shows `ctl_valid` 1, `op` 0011, `regsel` 10, `regwrite` 1, `alusrc` 0, `stall_fetch` 0.
- `beq` accepted at t, `ex_resolve` pulsed at t+4 → `stall_fetch` is 1 for cycles t..t+4. Outputs show `branch` 000, `x_ex` 1, `pcsrc` 01, `op` 0100 at t+1, then bubbles through t+5. An `addi` presented at t+5 appears at t+6.
- MUL_LAT = 3, `mul` at t → `op` 0101 at t+1; bubbles at t+2 and t+3; `stall_fetch` 1 for t..t+2.
- NUM_GPIO = 4, csrrw with `imm12` = 12'h005 → `gpio_we` 4'b1000, `regwrite` 0. With `imm12` = 12'h006 → `illegal` 1, `gpio_we` 0.
- `rst_n` dropped mid-CWAIT (asynchronously, between clock edges) → all outputs 0 immediately. After release, an `xori` is accepted with no extra stall.
- Undefined opcode 7'b0000000 → `illegal` 1, `ctl_valid` 0 for one cycle, `stall_fetch` 0.
